id_stage: RTL and testbench

//  Decode stage: consumer end of the IF/ID interface. Takes instr/PC_n from the IF_ID register,

---
 rtl/riscv_pkg.sv | 74 +++++++
 rtl/reg_file.sv | 40 ++++
 rtl/id_stage.sv | 182 ++++++++++++++++++
 tb/tb_id_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operation codes, instruction formats
// and the ID/EX bundle layout.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // ALU codes are {instr[30] qualifier, funct3} so OP/OP-IMM map directly.
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [31:0] INSTR_BUBBLE = 32'h0000_0000;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } id_ex_t;

    function automatic logic [31:0] imm_gen(input fmt_t fmt, input logic [31:0] ins);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   imm = {ins[31:12], 12'b0};
            FMT_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file, two read ports and one write port; x0 is hardwired to zero.
// With RF_BYPASS set, a same-cycle write is forwarded to the reads (write-first).
module reg_file
    import riscv_pkg::*;
#(
    parameter bit RF_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_idx,
    input  logic [31:0] wr_data
);

    logic [31:0] regs [32];
    logic        wr_live;

    assign wr_live = wr_en && (wr_idx != 5'd0);

    always_ff @(posedge clk) begin
        if (wr_live) begin
            regs[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rs1_data = 32'h0;
        rs2_data = 32'h0;
        if (rs1 != 5'd0) begin
            rs1_data = (RF_BYPASS && wr_live && wr_idx == rs1) ? wr_data : regs[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_data = (RF_BYPASS && wr_live && wr_idx == rs2) ? wr_data : regs[rs2];
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes the IF/ID instruction, reads the register file,
// detects load-use hazards and registers the ID/EX bundle.
module id_stage
    import riscv_pkg::*;
#(
    parameter bit RF_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] PC_n,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_funct3,
    output logic [3:0]  ex_alu_op,
    output logic        ex_alu_src,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_reg_write,
    output logic        ex_branch,
    output logic        ex_jump,
    output logic        ex_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    fmt_t        fmt;
    logic        legal;
    logic        illegal;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        hazard;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    id_ex_t      dec;
    id_ex_t      ex_q;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    always_comb begin
        fmt   = FMT_NONE;
        legal = 1'b1;
        dec   = '0;
        case (opcode)
            OPC_LUI: begin
                fmt = FMT_U;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_PASSB;
            end
            OPC_AUIPC: begin
                fmt = FMT_U;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OPC_JAL: begin
                fmt = FMT_J;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.jump      = 1'b1;
            end
            OPC_JALR: begin
                fmt = FMT_I;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.jump      = 1'b1;
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
            end
            OPC_LOAD: begin
                fmt = FMT_I;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.mem_read  = 1'b1;
            end
            OPC_STORE: begin
                fmt = FMT_S;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OPC_OPIMM: begin
                fmt = FMT_I;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = {(funct3 == 3'b101) && instr[30], funct3};
            end
            OPC_OP: begin
                fmt = FMT_R;
                dec.reg_write = 1'b1;
                dec.alu_op    = {(funct3 == 3'b000 || funct3 == 3'b101) && instr[30], funct3};
            end
            OPC_FENCE: begin
                fmt = FMT_NONE;
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        uses_rs1 = legal && (opcode != OPC_LUI) && (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
        uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
        rs1_idx  = uses_rs1 ? instr[19:15] : 5'd0;
        rs2_idx  = uses_rs2 ? instr[24:20] : 5'd0;

        dec.valid    = legal;
        dec.pc       = PC_n - 32'd4;
        dec.imm      = imm_gen(fmt, instr);
        dec.rs1      = rs1_idx;
        dec.rs2      = rs2_idx;
        dec.rd       = dec.reg_write ? instr[11:7] : 5'd0;
        dec.funct3   = funct3;
        dec.rs1_data = rs1_data;
        dec.rs2_data = rs2_data;
    end

    // An all-zero word is a fetch bubble, not an illegal instruction.
    assign illegal = !legal && (instr != INSTR_BUBBLE);

    assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                    ((uses_rs1 && rs1_idx == ex_q.rd) || (uses_rs2 && rs2_idx == ex_q.rd));
    assign stall  = !reset && !flush && hazard;

    reg_file #(
        .RF_BYPASS (RF_BYPASS)
    ) u_reg_file (
        .clk      (clk),
        .rs1      (rs1_idx),
        .rs2      (rs2_idx),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_en    (wb_en),
        .wr_idx   (wb_rd),
        .wr_data  (wb_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else if (flush || stall || !legal) begin
            ex_q         <= '0;
            ex_q.illegal <= illegal && !flush;
        end else begin
            ex_q <= dec;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_imm       = ex_q.imm;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;
    assign ex_funct3    = ex_q.funct3;
    assign ex_alu_op    = ex_q.alu_op;
    assign ex_alu_src   = ex_q.alu_src;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_branch    = ex_q.branch;
    assign ex_jump      = ex_q.jump;
    assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table, hand-written hazard/flush/illegal sequences
// and random instruction streams checked against a behavioural decode model.
module tb_id_stage;
    import riscv_pkg::*;

    localparam bit BYPASS = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] pc_n;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
    logic        ex_branch, ex_jump, ex_illegal;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [3:0]  ex_alu_op;

    always #5 clk = ~clk;

    id_stage #(.RF_BYPASS(BYPASS)) dut (
        .clk(clk), .reset(reset), .instr(instr), .PC_n(pc_n), .flush(flush),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal)
    );

    id_ex_t act;
    assign act = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                  ex_funct3, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
                  ex_branch, ex_jump, ex_illegal};

    int          tests = 0;
    int          fails = 0;
    logic [31:0] rf_m [32];
    id_ex_t      prev = '0;
    logic        stall_exp;
    logic        stall_obs;

    task automatic check32(input string name, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic check_bundle(input string name, input id_ex_t a, input id_ex_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    function automatic logic [31:0] rf_read(input logic [4:0] idx, input logic we,
                                            input logic [4:0] wrd, input logic [31:0] wd);
        if (idx == 5'd0) return 32'h0;
        if (BYPASS && we && wrd == idx) return wd;
        return rf_m[idx];
    endfunction

    // Behavioural decode straight from the ISA field definitions.
    function automatic id_ex_t ref_decode(input logic [31:0] ins, input logic [31:0] pcn,
                                          input logic we, input logic [4:0] wrd,
                                          input logic [31:0] wd);
        id_ex_t b;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        int i_imm, b_imm, j_imm;
        logic [31:0] s_imm, u_imm;
        logic u1, u2, wr;
        b     = '0;
        i_imm = int'($signed(ins)) >>> 20;
        s_imm = (i_imm & 32'hFFFF_FFE0) | {27'b0, ins[11:7]};
        b13   = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        b_imm = b13;
        j21   = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        j_imm = j21;
        u_imm = ins & 32'hFFFF_F000;
        u1 = 1'b1; u2 = 1'b0; wr = 1'b0;
        case (ins[6:0])
            7'b0110111: begin u1 = 0; wr = 1; b.alu_src = 1; b.alu_op = ALU_PASSB; b.imm = u_imm; end
            7'b0010111: begin u1 = 0; wr = 1; b.alu_src = 1; b.alu_op = ALU_ADD; b.imm = u_imm; end
            7'b1101111: begin u1 = 0; wr = 1; b.alu_src = 1; b.jump = 1; b.imm = j_imm; end
            7'b1100111: begin wr = 1; b.alu_src = 1; b.jump = 1; b.imm = i_imm; end
            7'b1100011: begin u2 = 1; b.branch = 1; b.alu_op = ALU_SUB; b.imm = b_imm; end
            7'b0000011: begin wr = 1; b.alu_src = 1; b.mem_read = 1; b.imm = i_imm; end
            7'b0100011: begin u2 = 1; b.alu_src = 1; b.mem_write = 1; b.imm = s_imm; end
            7'b0010011: begin
                wr = 1; b.alu_src = 1; b.imm = i_imm;
                case (ins[14:12])
                    3'd0: b.alu_op = ALU_ADD;  3'd1: b.alu_op = ALU_SLL;
                    3'd2: b.alu_op = ALU_SLT;  3'd3: b.alu_op = ALU_SLTU;
                    3'd4: b.alu_op = ALU_XOR;  3'd5: b.alu_op = ins[30] ? ALU_SRA : ALU_SRL;
                    3'd6: b.alu_op = ALU_OR;   default: b.alu_op = ALU_AND;
                endcase
            end
            7'b0110011: begin
                wr = 1; u2 = 1;
                case (ins[14:12])
                    3'd0: b.alu_op = ins[30] ? ALU_SUB : ALU_ADD;
                    3'd1: b.alu_op = ALU_SLL;  3'd2: b.alu_op = ALU_SLT;
                    3'd3: b.alu_op = ALU_SLTU; 3'd4: b.alu_op = ALU_XOR;
                    3'd5: b.alu_op = ins[30] ? ALU_SRA : ALU_SRL;
                    3'd6: b.alu_op = ALU_OR;   default: b.alu_op = ALU_AND;
                endcase
            end
            7'b0001111: begin end
            default: begin
                b.illegal = (ins != 32'h0);
                return b;
            end
        endcase
        b.valid     = 1'b1;
        b.reg_write = wr;
        b.pc        = pcn - 32'd4;
        b.funct3    = ins[14:12];
        b.rd        = wr ? ins[11:7] : 5'd0;
        b.rs1       = u1 ? ins[19:15] : 5'd0;
        b.rs2       = u2 ? ins[24:20] : 5'd0;
        b.rs1_data  = rf_read(b.rs1, we, wrd, wd);
        b.rs2_data  = rf_read(b.rs2, we, wrd, wd);
        return b;
    endfunction

    // One clock: drive inputs, check stall before the edge, check ID/EX after it.
    task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pcn,
                        input logic fl, input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd);
        id_ex_t d, nxt;
        logic es;
        reset = r; instr = ins; pc_n = pcn; flush = fl;
        wb_en = we; wb_rd = wrd; wb_data = wd;
        d  = ref_decode(ins, pcn, we, wrd, wd);
        es = !r && !fl && prev.valid && prev.mem_read && (prev.rd != 5'd0) &&
             (d.rs1 == prev.rd || d.rs2 == prev.rd);
        #3;
        stall_obs = stall;
        check32("stall", {31'b0, stall}, {31'b0, es});
        nxt = (r || fl || es) ? id_ex_t'('0) : d;
        @(posedge clk);
        #1;
        if (we && wrd != 5'd0) rf_m[wrd] = wd;
        check_bundle("id_ex", act, nxt);
        prev      = nxt;
        stall_exp = es;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pcn;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [6:0]  ctl;  // {valid, alu_src, mem_read, mem_write, reg_write, branch, jump}
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] ins;
        logic [6:0]  opcs [10];
        opcs = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};
        vecs[0]  = '{32'h0050_0093, 32'h0000_0010, 32'h0000_0005, ALU_ADD,   7'b1100100};
        vecs[1]  = '{32'h1234_5137, 32'h0000_0014, 32'h1234_5000, ALU_PASSB, 7'b1100100};
        vecs[2]  = '{32'h0000_1197, 32'h0000_0018, 32'h0000_1000, ALU_ADD,   7'b1100100};
        vecs[3]  = '{32'h0080_00EF, 32'h0000_001C, 32'h0000_0008, ALU_ADD,   7'b1100101};
        vecs[4]  = '{32'h0000_8067, 32'h0000_0020, 32'h0000_0000, ALU_ADD,   7'b1100101};
        vecs[5]  = '{32'hFE20_8CE3, 32'h0000_0104, 32'hFFFF_FFF8, ALU_SUB,   7'b1000010};
        vecs[6]  = '{32'hFE20_AE23, 32'h0000_0028, 32'hFFFF_FFFC, ALU_ADD,   7'b1101000};
        vecs[7]  = '{32'h0000_A283, 32'h0000_002C, 32'h0000_0000, ALU_ADD,   7'b1110100};
        vecs[8]  = '{32'h4030_D393, 32'h0000_0030, 32'h0000_0403, ALU_SRA,   7'b1100100};
        vecs[9]  = '{32'h4020_8433, 32'h0000_0034, 32'h0000_0000, ALU_SUB,   7'b1000100};
        vecs[10] = '{32'hFFF0_C493, 32'h0000_0038, 32'hFFFF_FFFF, ALU_XOR,   7'b1100100};
        vecs[11] = '{32'h0FF0_000F, 32'h0000_003C, 32'h0000_0000, ALU_ADD,   7'b1000000};

        // Reset held two cycles with a live instruction, then released.
        step(1'b1, 32'h0050_0093, 32'h4, 1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b1, 32'h0050_0093, 32'h4, 1'b0, 1'b0, 5'd0, 32'h0);
        check_bundle("reset_zero", act, id_ex_t'('0));
        step(1'b0, 32'h0050_0093, 32'h4, 1'b0, 1'b0, 5'd0, 32'h0);
        check32("rst_rel_imm", ex_imm, 32'd5);
        check32("rst_rel_ctl", {ex_rd, ex_alu_src, ex_reg_write}, {5'd1, 1'b1, 1'b1});

        // Preload the register file; the first writes happen under reset and must commit.
        for (int i = 1; i < 32; i++) begin
            step(i < 4, 32'h0, 32'h0, 1'b0, 1'b1, 5'(i), 32'h1000_0000 + 32'h0101 * i);
        end
        step(1'b0, 32'h0000_0133, 32'h8, 1'b0, 1'b0, 5'd0, 32'h0);  // add x2,x0,x0
        step(1'b0, 32'h0000_8033, 32'h8, 1'b0, 1'b0, 5'd0, 32'h0);  // add x0,x1,x0
        check32("wr_under_reset", ex_rs1_data, 32'h1000_0101);

        // Same-cycle writeback is visible through the bypass.
        step(1'b0, 32'h0001_8233, 32'h8, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
        check32("rf_bypass", ex_rs1_data, BYPASS ? 32'hDEAD_BEEF : 32'h1000_0303);

        // Directed vector table.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        foreach (vecs[k]) begin
            step(1'b0, vecs[k].ins, vecs[k].pcn, 1'b0, 1'b0, 5'd0, 32'h0);
            check32($sformatf("vec%0d_imm", k), ex_imm, vecs[k].imm);
            check32($sformatf("vec%0d_op", k), {28'b0, ex_alu_op}, {28'b0, vecs[k].alu_op});
            check32($sformatf("vec%0d_ctl", k),
                    {25'b0, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
                     ex_branch, ex_jump}, {25'b0, vecs[k].ctl});
        end
        check32("beq_pc", vecs[5].pcn - 32'd4, 32'h100);
        step(1'b0, 32'hFE20_8CE3, 32'h104, 1'b0, 1'b0, 5'd0, 32'h0);
        check32("beq_ex_pc", ex_pc, 32'h100);
        step(1'b0, 32'h0050_0093, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        check32("pc_wrap", ex_pc, 32'hFFFF_FFFC);

        // Load-use: one stall cycle, one bubble, then the add issues.
        step(1'b0, 32'h0000_A283, 32'h40, 1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b0, 32'h0022_8333, 32'h44, 1'b0, 1'b0, 5'd0, 32'h0);
        check32("lu_stall", {31'b0, stall_obs}, 32'd1);
        check32("lu_bubble", {31'b0, ex_valid}, 32'd0);
        step(1'b0, 32'h0022_8333, 32'h44, 1'b0, 1'b0, 5'd0, 32'h0);
        check32("lu_release", {31'b0, stall_obs}, 32'd0);
        check32("lu_issue", {26'b0, ex_valid, ex_rs1}, {26'b0, 1'b1, 5'd5});

        // Load into x0 never stalls.
        step(1'b0, 32'h0000_A003, 32'h48, 1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b0, 32'h0020_0333, 32'h4C, 1'b0, 1'b0, 5'd0, 32'h0);
        check32("lu_x0", {31'b0, stall_obs}, 32'd0);

        // Flush wins over a load-use stall.
        step(1'b0, 32'h0000_A283, 32'h50, 1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b0, 32'h0022_8333, 32'h54, 1'b1, 1'b0, 5'd0, 32'h0);
        check32("flush_stall", {30'b0, stall_obs, ex_valid}, 32'd0);

        // Illegal opcode pulses once; with flush it is suppressed.
        step(1'b0, 32'hFFFF_FFFF, 32'h58, 1'b0, 1'b0, 5'd0, 32'h0);
        check32("ill_pulse", {30'b0, ex_illegal, ex_valid}, 32'd2);
        step(1'b0, 32'h0, 32'h5C, 1'b0, 1'b0, 5'd0, 32'h0);
        check32("ill_clear", {31'b0, ex_illegal}, 32'd0);
        step(1'b0, 32'hFFFF_FFFF, 32'h60, 1'b1, 1'b0, 5'd0, 32'h0);
        check32("ill_flush", {31'b0, ex_illegal}, 32'd0);

        // Random stream with a fetch model that holds the instruction on stall.
        ins = 32'h0;
        for (int n = 0; n < 400; n++) begin
            if (!stall_exp) begin
                ins = $urandom;
                if ($urandom_range(0, 19) == 0) ins = 32'h0;
                else if ($urandom_range(0, 19) == 0) ins[6:0] = 7'b1010111;
                else begin
                    ins[6:0]   = opcs[$urandom_range(0, 9)];
                    ins[11:7]  = 5'($urandom_range(0, 7));
                    ins[19:15] = 5'($urandom_range(0, 7));
                    ins[24:20] = 5'($urandom_range(0, 7));
                end
            end
            step($urandom_range(0, 99) == 0, ins, {$urandom_range(0, 255), 2'b00},
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 7)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
